// File: rtl/imem_loader.sv
// Frames a UART byte stream into 16-bit words for the instruction RAM write port.
// Holds the CPU in reset while an image loads and answers each frame with ACK or NAK.
module imem_loader #(
   parameter int          ADDR_WIDTH     = 12,
   parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
   parameter logic [7:0]  ACK_BYTE       = 8'h06,
   parameter logic [7:0]  NAK_BYTE       = 8'h15,
   parameter int          TIMEOUT_CYCLES = 1000000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [7:0]            rx_data,
   input  logic                  rx_valid,
   output logic [7:0]            ack_data,
   output logic                  ack_valid,
   input  logic                  ack_ready,
   output logic [ADDR_WIDTH-1:0] w_addr,
   output logic [15:0]           w_data,
   output logic                  w_en,
   output logic                  cpu_hold,
   output logic                  done,
   output logic                  error
);

   // state   | meaning
   // IDLE    | waiting for SYNC_BYTE, other bytes ignored
   // LEN_HI  | expecting word count high byte
   // LEN_LO  | expecting word count low byte, count validated here
   // DATA_HI | expecting high byte of next word
   // DATA_LO | expecting low byte, word written on the following clock
   // CSUM    | expecting 8-bit sum of all data bytes
   // RESP    | ack_valid held until ack_ready
   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_LEN_HI  = 3'd1;
   localparam logic [2:0] S_LEN_LO  = 3'd2;
   localparam logic [2:0] S_DATA_HI = 3'd3;
   localparam logic [2:0] S_DATA_LO = 3'd4;
   localparam logic [2:0] S_CSUM    = 3'd5;
   localparam logic [2:0] S_RESP    = 3'd6;

   localparam int              IW       = ADDR_WIDTH + 1;
   localparam int              TW       = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0]   TMR_LOAD = TW'(TIMEOUT_CYCLES - 1);

   logic [2:0]            state_q, state_d;
   logic [15:0]           len_q, len_d;
   logic [7:0]            hi_q, hi_d;
   logic [7:0]            sum_q, sum_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [TW-1:0]         tmr_q, tmr_d;
   logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
   logic [15:0]           w_data_q, w_data_d;
   logic                  w_en_q, w_en_d;
   logic [7:0]            ack_data_q, ack_data_d;
   logic                  ack_valid_q, ack_valid_d;
   logic                  done_q, done_d;
   logic                  error_q, error_d;
   logic                  cpu_hold_q, cpu_hold_d;

   logic                  in_frame;
   logic                  timeout;
   logic [15:0]           n_w;

   assign in_frame = (state_q >= S_LEN_HI) && (state_q <= S_CSUM);
   assign timeout  = in_frame && !rx_valid && (tmr_q == '0);
   assign n_w      = {len_q[15:8], rx_data};

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      hi_d        = hi_q;
      sum_d       = sum_q;
      idx_d       = idx_q;
      tmr_d       = tmr_q;
      w_addr_d    = w_addr_q;
      w_data_d    = w_data_q;
      w_en_d      = 1'b0;
      ack_data_d  = ack_data_q;
      ack_valid_d = ack_valid_q;
      done_d      = 1'b0;
      error_d     = error_q;
      cpu_hold_d  = cpu_hold_q;

      // Idle timer: reloads on every byte, runs down only while a frame is open.
      if (rx_valid)
         tmr_d = TMR_LOAD;
      else if (in_frame && tmr_q != '0)
         tmr_d = tmr_q - TW'(1);

      if (timeout) begin
         error_d     = 1'b1;
         ack_data_d  = NAK_BYTE;
         ack_valid_d = 1'b1;
         state_d     = S_RESP;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (rx_valid && rx_data == SYNC_BYTE) begin
                  state_d    = S_LEN_HI;
                  cpu_hold_d = 1'b1;
                  error_d    = 1'b0;
                  sum_d      = '0;
                  idx_d      = '0;
               end
            end
            S_LEN_HI: begin
               if (rx_valid) begin
                  len_d   = {rx_data, 8'h00};
                  state_d = S_LEN_LO;
               end
            end
            S_LEN_LO: begin
               if (rx_valid) begin
                  len_d = n_w;
                  if (n_w == 16'd0 || 32'(n_w) > (32'd1 << ADDR_WIDTH)) begin
                     error_d     = 1'b1;
                     ack_data_d  = NAK_BYTE;
                     ack_valid_d = 1'b1;
                     state_d     = S_RESP;
                  end else begin
                     state_d = S_DATA_HI;
                  end
               end
            end
            S_DATA_HI: begin
               if (rx_valid) begin
                  hi_d    = rx_data;
                  sum_d   = sum_q + rx_data;
                  state_d = S_DATA_LO;
               end
            end
            S_DATA_LO: begin
               if (rx_valid) begin
                  sum_d    = sum_q + rx_data;
                  w_en_d   = 1'b1;
                  w_addr_d = idx_q[ADDR_WIDTH-1:0];
                  w_data_d = {hi_q, rx_data};
                  idx_d    = idx_q + IW'(1);
                  state_d  = ((idx_q + IW'(1)) == IW'(len_q)) ? S_CSUM : S_DATA_HI;
               end
            end
            S_CSUM: begin
               if (rx_valid) begin
                  ack_valid_d = 1'b1;
                  state_d     = S_RESP;
                  if (rx_data == sum_q) begin
                     ack_data_d = ACK_BYTE;
                  end else begin
                     ack_data_d = NAK_BYTE;
                     error_d    = 1'b1;
                  end
               end
            end
            S_RESP: begin
               // A NAK leaves cpu_hold set so a corrupt image never starts.
               if (ack_ready) begin
                  ack_valid_d = 1'b0;
                  state_d     = S_IDLE;
                  if (ack_data_q == ACK_BYTE) begin
                     done_d     = 1'b1;
                     cpu_hold_d = 1'b0;
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         len_q       <= '0;
         hi_q        <= '0;
         sum_q       <= '0;
         idx_q       <= '0;
         tmr_q       <= '0;
         w_addr_q    <= '0;
         w_data_q    <= '0;
         w_en_q      <= 1'b0;
         ack_data_q  <= '0;
         ack_valid_q <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         cpu_hold_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         hi_q        <= hi_d;
         sum_q       <= sum_d;
         idx_q       <= idx_d;
         tmr_q       <= tmr_d;
         w_addr_q    <= w_addr_d;
         w_data_q    <= w_data_d;
         w_en_q      <= w_en_d;
         ack_data_q  <= ack_data_d;
         ack_valid_q <= ack_valid_d;
         done_q      <= done_d;
         error_q     <= error_d;
         cpu_hold_q  <= cpu_hold_d;
      end
   end

   assign ack_data  = ack_data_q;
   assign ack_valid = ack_valid_q;
   assign w_addr    = w_addr_q;
   assign w_data    = w_data_q;
   assign w_en      = w_en_q;
   assign cpu_hold  = cpu_hold_q;
   assign done      = done_q;
   assign error     = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: good/bad frames, length limits, timeout, reset mid-frame.
module tb_imem_loader;

   localparam int TMO = 50;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [7:0]  ack_data;
   logic        ack_valid;
   logic        ack_ready;
   logic [11:0] w_addr;
   logic [15:0] w_data;
   logic        w_en;
   logic        cpu_hold;
   logic        done;
   logic        error;

   int n_chk  = 0;
   int n_fail = 0;
   int wen_total = 0;
   logic w_en_prev = 1'b0;
   logic        snap_en;
   logic [11:0] snap_addr;
   logic [15:0] snap_data;
   int          wen_base;

   imem_loader #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
      .ack_data(ack_data), .ack_valid(ack_valid), .ack_ready(ack_ready),
      .w_addr(w_addr), .w_data(w_data), .w_en(w_en),
      .cpu_hold(cpu_hold), .done(done), .error(error)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (w_en) begin
         wen_total++;
         check("w_en_one_cycle", {31'd0, w_en_prev}, 32'd0);
      end
      w_en_prev = w_en;
   end

   // One-cycle strobe; snapshot the write port on the clock after the byte is taken.
   task automatic send(input logic [7:0] b);
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid  = 1'b0;
      snap_en   = w_en;
      snap_addr = w_addr;
      snap_data = w_data;
   endtask

   task automatic send_lo(input logic [7:0] b, input logic [11:0] ea, input logic [15:0] ed);
      send(b);
      check("wr_en", {31'd0, snap_en}, 32'd1);
      check("wr_addr", {20'd0, snap_addr}, {20'd0, ea});
      check("wr_data", {16'd0, snap_data}, {16'd0, ed});
   endtask

   task automatic wait_resp(input logic [7:0] exp, input int hold,
                            input logic exp_done, input logic exp_hold);
      for (int i = 0; i < 20 && !ack_valid; i++) @(negedge clk);
      check("resp_seen", {31'd0, ack_valid}, 32'd1);
      check("ack_data", {24'd0, ack_data}, {24'd0, exp});
      for (int i = 0; i < hold; i++) begin
         rx_data  = 8'hA5;
         rx_valid = (i % 2 == 0);
         @(negedge clk);
         check("hold_valid", {31'd0, ack_valid}, 32'd1);
         check("hold_data", {24'd0, ack_data}, {24'd0, exp});
      end
      rx_valid  = 1'b0;
      ack_ready = 1'b1;
      @(negedge clk);
      ack_ready = 1'b0;
      check("ack_drop", {31'd0, ack_valid}, 32'd0);
      check("done_pulse", {31'd0, done}, {31'd0, exp_done});
      check("cpu_hold_after", {31'd0, cpu_hold}, {31'd0, exp_hold});
      @(negedge clk);
      check("done_low", {31'd0, done}, 32'd0);
   endtask

   task automatic check_reset_outputs();
      check("rst_w_en", {31'd0, w_en}, 32'd0);
      check("rst_ack_valid", {31'd0, ack_valid}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_error", {31'd0, error}, 32'd0);
      check("rst_cpu_hold", {31'd0, cpu_hold}, 32'd0);
      check("rst_w_addr", {20'd0, w_addr}, 32'd0);
      check("rst_w_data", {16'd0, w_data}, 32'd0);
   endtask

   initial begin
      reset = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; ack_ready = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_reset_outputs();

      // Noise in IDLE is ignored
      send(8'h00); send(8'hFF); send(8'h55);
      check("idle_hold", {31'd0, cpu_hold}, 32'd0);
      check("idle_ack", {31'd0, ack_valid}, 32'd0);
      check("idle_wen", wen_total, 32'd0);

      // Good frame; checksum 12+34+AB+CD = 1BE -> BE
      send(8'hA5);
      check("sync_hold", {31'd0, cpu_hold}, 32'd1);
      send(8'h00); send(8'h02);
      send(8'h12); send_lo(8'h34, 12'd0, 16'h1234);
      send(8'hAB); send_lo(8'hCD, 12'd1, 16'hABCD);
      send(8'hBE);
      wait_resp(8'h06, 10, 1'b1, 1'b0);
      check("good_error", {31'd0, error}, 32'd0);
      check("good_wen", wen_total, 32'd2);

      // Bad checksum: words still written, NAK, hold kept
      send(8'hA5); send(8'h00); send(8'h02);
      send(8'h12); send_lo(8'h34, 12'd0, 16'h1234);
      send(8'hAB); send_lo(8'hCD, 12'd1, 16'hABCD);
      send(8'h00);
      check("csum_error", {31'd0, error}, 32'd1);
      wait_resp(8'h15, 0, 1'b0, 1'b1);
      check("csum_wen", wen_total, 32'd4);

      // Zero length
      wen_base = wen_total;
      send(8'hA5);
      check("sync_clr_err", {31'd0, error}, 32'd0);
      send(8'h00); send(8'h00);
      check("len0_error", {31'd0, error}, 32'd1);
      wait_resp(8'h15, 0, 1'b0, 1'b1);

      // One past the RAM size
      send(8'hA5); send(8'h10); send(8'h01);
      wait_resp(8'h15, 0, 1'b0, 1'b1);
      check("len_big_wen", wen_total, wen_base);

      // Full RAM size accepted, then reset while waiting for a low byte
      send(8'hA5); send(8'h10); send(8'h00);
      repeat (3) @(negedge clk);
      check("len_max_ok", {31'd0, ack_valid}, 32'd0);
      send(8'h11);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_reset_outputs();

      // Fresh frame with a SYNC value carried as data
      send(8'hA5); send(8'h00); send(8'h01);
      send(8'hA5); send_lo(8'h5A, 12'd0, 16'hA55A);
      send(8'hFF);
      wait_resp(8'h06, 0, 1'b1, 1'b0);

      // Timeout after a lone high byte
      send(8'hA5); send(8'h00); send(8'h01); send(8'h12);
      repeat (TMO - 1) @(negedge clk);
      check("tmo_early", {31'd0, ack_valid}, 32'd0);
      @(negedge clk);
      check("tmo_fire", {31'd0, ack_valid}, 32'd1);
      check("tmo_error", {31'd0, error}, 32'd1);
      wait_resp(8'h15, 0, 1'b0, 1'b1);

      // Back in IDLE: noise ignored, next good frame releases the CPU
      send(8'h00);
      check("post_tmo_idle", {31'd0, ack_valid}, 32'd0);
      send(8'hA5); send(8'h00); send(8'h01);
      send(8'h01); send_lo(8'h02, 12'd0, 16'h0102);
      send(8'h03);
      wait_resp(8'h06, 0, 1'b1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
